// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared pipeline definitions for the forwarding and hazard controller.
package hazard_forward_ctrl_pkg;

    // EX operand mux select encodings
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic [1:0] FWD_WB  = 2'b01;

    // Memory-wait tracking state
    typedef enum logic {
        RUN,
        WAIT
    } state_e;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: stage destinations and
// memory handshake in, forward selects and stall controls out.
interface hazard_forward_ctrl_if #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int CNT_W   = 32
);
    logic [NUM_SRC*AW-1:0] id_rs;
    logic [NUM_SRC-1:0]    id_rs_used;
    logic [AW-1:0]         ex_rd;
    logic                  ex_RegWEn;
    logic                  ex_MemRead;
    logic [AW-1:0]         mem_rd;
    logic                  mem_RegWEn;
    logic                  mem_MemRead;
    logic                  mem_req;
    logic                  mem_ready;
    logic [AW-1:0]         wb_rd;
    logic                  wb_RegWEn;

    logic [2*NUM_SRC-1:0]  ex_fwd;
    logic [NUM_SRC-1:0]    id_wb_bypass;
    logic                  pc_stall;
    logic                  ifid_stall;
    logic                  idex_flush;
    logic                  pipe_freeze;
    logic                  err_timeout;
    logic [CNT_W-1:0]      stall_cnt;

    // Pipeline side: drives stage info, observes controls
    modport master (
        output id_rs, id_rs_used, ex_rd, ex_RegWEn, ex_MemRead,
               mem_rd, mem_RegWEn, mem_MemRead, mem_req, mem_ready,
               wb_rd, wb_RegWEn,
        input  ex_fwd, id_wb_bypass, pc_stall, ifid_stall, idex_flush,
               pipe_freeze, err_timeout, stall_cnt
    );

    // Controller side
    modport slave (
        input  id_rs, id_rs_used, ex_rd, ex_RegWEn, ex_MemRead,
               mem_rd, mem_RegWEn, mem_MemRead, mem_req, mem_ready,
               wb_rd, wb_RegWEn,
        output ex_fwd, id_wb_bypass, pc_stall, ifid_stall, idex_flush,
               pipe_freeze, err_timeout, stall_cnt
    );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_src_match.sv
// Per-source producer matching: picks the youngest usable producer for one
// ID source operand and flags load-use and WB-bypass conditions.
module fwd_src_match
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic [AW-1:0] rs_i,
    input  logic          used_i,
    input  logic [AW-1:0] ex_rd_i,
    input  logic          ex_regwen_i,
    input  logic          ex_memread_i,
    input  logic [AW-1:0] mem_rd_i,
    input  logic          mem_regwen_i,
    input  logic [AW-1:0] wb_rd_i,
    input  logic          wb_regwen_i,
    output logic [1:0]    nf_o,
    output logic          bypass_o,
    output logic          load_use_o
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so a zero destination never counts as a producer
    assign ex_hit  = used_i & ex_regwen_i  & (ex_rd_i  == rs_i) & (ex_rd_i  != '0);
    assign mem_hit = used_i & mem_regwen_i & (mem_rd_i == rs_i) & (mem_rd_i != '0);
    assign wb_hit  = used_i & wb_regwen_i  & (wb_rd_i  == rs_i) & (wb_rd_i  != '0);

    // Youngest producer wins; a load in EX has no data yet and falls through
    always_comb begin
        nf_o = FWD_REG;
        if (ex_hit && !ex_memread_i) begin
            nf_o = FWD_MEM;
        end else if (mem_hit) begin
            nf_o = FWD_WB;
        end
    end

    assign bypass_o   = wb_hit;
    assign load_use_o = ex_hit & ex_memread_i;

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forwarding and hazard controller for the 5-stage pipeline: registered EX
// forward selects, load-use bubbles, memory-wait freeze, timeout flag and
// stall performance counter.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int NUM_SRC  = 2,
    parameter int AW       = 5,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_forward_ctrl_if.slave bus
);

    localparam int             WCW        = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    logic [2*NUM_SRC-1:0] nf;
    logic [NUM_SRC-1:0]   bypass_raw;
    logic [NUM_SRC-1:0]   lu_vec;
    logic                 load_use;
    logic                 mem_wait;
    logic                 pc_stall;
    logic                 idex_flush;
    logic                 pipe_freeze;

    state_e               state_q, state_d;
    logic [WCW-1:0]       wcnt_q, wcnt_d;
    logic                 err_q, err_d;
    logic [2*NUM_SRC-1:0] fwd_q, fwd_d;
    logic [CNT_W-1:0]     scnt_q, scnt_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_src_match #(.AW(AW)) u_match (
            .rs_i         (bus.id_rs[i*AW +: AW]),
            .used_i       (bus.id_rs_used[i]),
            .ex_rd_i      (bus.ex_rd),
            .ex_regwen_i  (bus.ex_RegWEn),
            .ex_memread_i (bus.ex_MemRead),
            .mem_rd_i     (bus.mem_rd),
            .mem_regwen_i (bus.mem_RegWEn),
            .wb_rd_i      (bus.wb_rd),
            .wb_regwen_i  (bus.wb_RegWEn),
            .nf_o         (nf[2*i +: 2]),
            .bypass_o     (bypass_raw[i]),
            .load_use_o   (lu_vec[i])
        );
    end

    assign load_use = |lu_vec;
    assign mem_wait = bus.mem_req & ~bus.mem_ready;

    // Stall decode: a memory wait freezes everything and outranks a load bubble
    always_comb begin
        pc_stall    = 1'b0;
        idex_flush  = 1'b0;
        pipe_freeze = 1'b0;
        if (!rst) begin
            if (mem_wait) begin
                pc_stall    = 1'b1;
                pipe_freeze = 1'b1;
            end else if (load_use) begin
                pc_stall   = 1'b1;
                idex_flush = 1'b1;
            end
        end
    end

    // Wait FSM next state; counter counts consecutive wait cycles including the entry cycle
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    state_d = WAIT;
                    wcnt_d  = WCW'(1);
                end else begin
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (mem_wait) begin
                    wcnt_d = (wcnt_q == WAIT_LIMIT) ? WAIT_LIMIT : wcnt_q + 1'b1;
                end else begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
        if (mem_wait && (wcnt_d == WAIT_LIMIT)) begin
            err_d = 1'b1;
        end
    end

    // Forward select and stall counter next values
    always_comb begin
        fwd_d = nf;
        if (pipe_freeze) begin
            fwd_d = fwd_q;
        end else if (idex_flush) begin
            fwd_d = '0;
        end
        scnt_d = pc_stall ? scnt_q + 1'b1 : scnt_q;
    end

    // Wait FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // EX forward select and stall counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_q  <= '0;
            scnt_q <= '0;
        end else begin
            fwd_q  <= fwd_d;
            scnt_q <= scnt_d;
        end
    end

    assign bus.ex_fwd       = fwd_q;
    assign bus.id_wb_bypass = rst ? '0 : bypass_raw;
    assign bus.pc_stall     = pc_stall;
    assign bus.ifid_stall   = pc_stall;
    assign bus.idex_flush   = idex_flush;
    assign bus.pipe_freeze  = pipe_freeze;
    assign bus.err_timeout  = err_q;
    assign bus.stall_cnt    = scnt_q;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Self-checking bench for hazard_forward_ctrl with three source operands.
module tb_hazard_forward_ctrl;

    localparam int NS = 3;
    localparam int AW = 5;
    localparam int MW = 15;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    hazard_forward_ctrl_if #(.NUM_SRC(NS), .AW(AW), .CNT_W(CW)) bus ();

    hazard_forward_ctrl #(
        .NUM_SRC (NS),
        .AW      (AW),
        .MAX_WAIT(MW),
        .CNT_W   (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // expCtl = {pc_stall, ifid_stall, idex_flush, pipe_freeze}; expFwd is ex_fwd after the edge
    typedef struct {
        logic [3*AW-1:0] rs;
        logic [2:0]      used;
        logic [4:0]      exRd;
        logic            exWe;
        logic            exMr;
        logic [4:0]      memRd;
        logic            memWe;
        logic            memMr;
        logic            memReq;
        logic            memReady;
        logic [4:0]      wbRd;
        logic            wbWe;
        logic [2:0]      expByp;
        logic [3:0]      expCtl;
        logic [5:0]      expFwd;
    } vec_t;

    vec_t          vecs[$];
    vec_t          expQ[$];
    int            compared   = 0;
    int            mismatched = 0;
    logic [CW-1:0] expStall   = '0;

    function automatic logic [3*AW-1:0] mkRs(input logic [4:0] r1, input logic [4:0] r2,
                                             input logic [4:0] r3);
        return {r3, r2, r1};
    endfunction

    function automatic vec_t mkVec(
        input logic [3*AW-1:0] rs, input logic [2:0] used,
        input logic [4:0] exRd, input logic exWe, input logic exMr,
        input logic [4:0] memRd, input logic memWe, input logic memMr,
        input logic memReq, input logic memReady,
        input logic [4:0] wbRd, input logic wbWe,
        input logic [2:0] expByp, input logic [3:0] expCtl, input logic [5:0] expFwd);
        vec_t v;
        v.rs = rs;         v.used = used;
        v.exRd = exRd;     v.exWe = exWe;     v.exMr = exMr;
        v.memRd = memRd;   v.memWe = memWe;   v.memMr = memMr;
        v.memReq = memReq; v.memReady = memReady;
        v.wbRd = wbRd;     v.wbWe = wbWe;
        v.expByp = expByp; v.expCtl = expCtl; v.expFwd = expFwd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic driveInputs(input vec_t v);
        bus.id_rs       = v.rs;
        bus.id_rs_used  = v.used;
        bus.ex_rd       = v.exRd;
        bus.ex_RegWEn   = v.exWe;
        bus.ex_MemRead  = v.exMr;
        bus.mem_rd      = v.memRd;
        bus.mem_RegWEn  = v.memWe;
        bus.mem_MemRead = v.memMr;
        bus.mem_req     = v.memReq;
        bus.mem_ready   = v.memReady;
        bus.wb_rd       = v.wbRd;
        bus.wb_RegWEn   = v.wbWe;
    endtask

    // Drive one vector mid-cycle, sample combinational outputs, then check registered ones after the edge
    task automatic applyStimulus(input vec_t v, input int idx);
        vec_t       e;
        logic [2:0] sByp;
        logic [3:0] sCtl;
        @(negedge clk);
        driveInputs(v);
        expQ.push_back(v);
        #2;
        sByp = bus.id_wb_bypass;
        sCtl = {bus.pc_stall, bus.ifid_stall, bus.idex_flush, bus.pipe_freeze};
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL v%0d scoreboard: got empty queue expected entry", idx);
        end else begin
            e = expQ.pop_front();
            if (e.expCtl[3]) expStall++;
            checkOutput($sformatf("v%0d bypass", idx), 64'(sByp), 64'(e.expByp));
            checkOutput($sformatf("v%0d ctl", idx), 64'(sCtl), 64'(e.expCtl));
            checkOutput($sformatf("v%0d ex_fwd", idx), 64'(bus.ex_fwd), 64'(e.expFwd));
            checkOutput($sformatf("v%0d stall_cnt", idx), 64'(bus.stall_cnt), 64'(expStall));
            checkOutput($sformatf("v%0d err", idx), 64'(bus.err_timeout), 64'(1'b0));
        end
    endtask

    // One cycle of memory access with no register hazards
    task automatic runWait(input string tag, input logic ready, input logic expErr);
        vec_t v;
        logic frz;
        v = mkVec('0, 3'b000, 0, 0, 0, 0, 0, 0, 1'b1, ready, 0, 0, 0, 0, 0);
        @(negedge clk);
        driveInputs(v);
        #2;
        frz = bus.pipe_freeze;
        @(posedge clk);
        #1;
        if (!ready) expStall++;
        checkOutput({tag, " freeze"}, 64'(frz), 64'(!ready));
        checkOutput({tag, " err"}, 64'(bus.err_timeout), 64'(expErr));
        checkOutput({tag, " stall_cnt"}, 64'(bus.stall_cnt), 64'(expStall));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t idle;
        vec_t lu;
        idle = mkVec('0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Table: table-driven single-cycle hazard scenarios
        vecs.push_back(idle);
        vecs.push_back(mkVec(mkRs(5, 0, 0), 3'b001, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 6'b000010));
        vecs.push_back(mkVec(mkRs(0, 6, 0), 3'b010, 6, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b1110, 6'b000000));
        vecs.push_back(mkVec(mkRs(0, 6, 0), 3'b010, 0, 0, 0, 6, 1, 1, 1, 1, 0, 0, 3'b000, 4'b0000, 6'b000100));
        vecs.push_back(mkVec(mkRs(7, 0, 0), 3'b001, 7, 1, 0, 7, 1, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 6'b000010));
        vecs.push_back(mkVec(mkRs(0, 0, 0), 3'b001, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 6'b000000));
        vecs.push_back(mkVec(mkRs(0, 0, 9), 3'b100, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 3'b100, 4'b0000, 6'b000000));
        vecs.push_back(mkVec(mkRs(0, 0, 9), 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 9, 1, 3'b000, 4'b0000, 6'b000000));
        vecs.push_back(mkVec(mkRs(3, 4, 0), 3'b011, 3, 1, 0, 4, 1, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 6'b000110));
        vecs.push_back(mkVec(mkRs(3, 0, 0), 3'b001, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 6'b000000));
        vecs.push_back(mkVec(mkRs(2, 0, 8), 3'b101, 8, 1, 1, 0, 0, 0, 0, 0, 2, 1, 3'b001, 4'b1110, 6'b000000));
        vecs.push_back(mkVec(mkRs(0, 0, 0), 3'b001, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 6'b000000));
        // Memory wait on top of a load-use: freeze wins and ex_fwd holds
        vecs.push_back(mkVec(mkRs(5, 0, 0), 3'b001, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 4'b0000, 6'b000010));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mkVec(mkRs(0, 6, 0), 3'b010, 6, 1, 1, 0, 0, 0, 1, 0, 0, 0, 3'b000, 4'b1101, 6'b000010));
        vecs.push_back(mkVec(mkRs(0, 6, 0), 3'b010, 6, 1, 1, 0, 0, 0, 1, 1, 0, 0, 3'b000, 4'b1110, 6'b000000));
        vecs.push_back(mkVec(mkRs(7, 0, 0), 3'b001, 0, 0, 0, 7, 1, 0, 0, 0, 7, 1, 3'b001, 4'b0000, 6'b000001));

        // Reset: outputs quiet even with a load-use and WB match presented
        lu = mkVec(mkRs(0, 6, 9), 3'b110, 6, 1, 1, 0, 0, 0, 0, 0, 9, 1, 0, 0, 0);
        rst = 1'b1;
        driveInputs(lu);
        #3;
        checkOutput("reset pc_stall", 64'(bus.pc_stall), 64'(1'b0));
        checkOutput("reset idex_flush", 64'(bus.idex_flush), 64'(1'b0));
        checkOutput("reset bypass", 64'(bus.id_wb_bypass), 64'(3'b000));
        checkOutput("reset ex_fwd", 64'(bus.ex_fwd), 64'(6'b0));
        checkOutput("reset err", 64'(bus.err_timeout), 64'(1'b0));
        checkOutput("reset stall_cnt", 64'(bus.stall_cnt), 64'(32'd0));
        @(posedge clk);
        #1;
        checkOutput("reset hold stall_cnt", 64'(bus.stall_cnt), 64'(32'd0));
        @(negedge clk);
        driveInputs(idle);
        rst = 1'b0;

        foreach (vecs[i]) applyStimulus(vecs[i], i);

        // Long memory wait: err_timeout rises at the edge closing the 15th wait cycle and sticks
        for (int k = 1; k <= 20; k++) runWait($sformatf("wait%0d", k), 1'b0, k >= MW);
        runWait("wait_done", 1'b1, 1'b1);
        for (int k = 1; k <= 3; k++) runWait($sformatf("rewait%0d", k), 1'b0, 1'b1);

        // Reset mid-wait clears everything immediately
        @(negedge clk);
        driveInputs(lu);
        bus.mem_req   = 1'b1;
        bus.mem_ready = 1'b0;
        rst = 1'b1;
        #1;
        expStall = '0;
        checkOutput("midwait pc_stall", 64'(bus.pc_stall), 64'(1'b0));
        checkOutput("midwait freeze", 64'(bus.pipe_freeze), 64'(1'b0));
        checkOutput("midwait bypass", 64'(bus.id_wb_bypass), 64'(3'b000));
        checkOutput("midwait err", 64'(bus.err_timeout), 64'(1'b0));
        checkOutput("midwait stall_cnt", 64'(bus.stall_cnt), 64'(32'd0));
        checkOutput("midwait ex_fwd", 64'(bus.ex_fwd), 64'(6'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Wait count restarts from zero after reset
        for (int k = 1; k <= MW; k++) runWait($sformatf("postrst%0d", k), 1'b0, k >= MW);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
